// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and depth for the two-entry skid buffer
package pipe_pkg;

  localparam int SKID_DEPTH = 2;

  // Encoding doubles as the occupancy count presented on the count port
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/skid_ctrl.sv
// rtl/skid_ctrl.sv - occupancy FSM and datapath load strobes for pipe_skid_reg
module skid_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        out_ready,
  input  logic        flush,
  output skid_state_t state,
  output logic        in_ready,
  output logic        out_valid,
  output logic        load_main,
  output logic        load_skid,
  output logic        main_from_skid
);

  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        in_xfer, out_xfer;

  // Next state and load strobes; handshakes qualify only on registered ready/valid
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    in_xfer        = in_valid & in_ready_q;
    out_xfer       = out_valid_q & out_ready;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any same-cycle transfer and leaves payload registers untouched
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // State and handshake flops; ready/valid are registered copies of the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state     = state_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry registered skid buffer; SKID_FLUSH_EN adds a flush input
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
`ifdef SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  skid_state_t      state;
  logic             load_main, load_skid, main_from_skid;
  logic             flush_i;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

`ifdef SKID_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  skid_ctrl u_ctrl (
    .clk            (clk),
    .rst            (reset),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .flush          (flush_i),
    .state          (state),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main      (load_main),
    .load_skid      (load_skid),
    .main_from_skid (main_from_skid)
  );

  // Payload muxes: main takes new input or the parked skid entry, skid only takes input
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main) begin
      main_d = in_data;
    end else if (main_from_skid) begin
      main_d = skid_q;
    end
    if (load_skid) begin
      skid_d = in_data;
    end
  end

  // Payload registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;
  assign count    = state;

endmodule
